// File: rtl/addsub_pipe_if.sv
// Operand/result bundle for addsub_pipe; slave is the unit, master is the producer/consumer.
interface addsub_pipe_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
    logic             i_Select;
    logic             i_Valid;
    logic             o_Ready;
    logic [WIDTH-1:0] o_Out;
    logic             o_Cout;
    logic             o_Overflow;
    logic             o_Zero;
    logic             o_Negative;
    logic             o_Valid;
    logic             i_Ready;

    modport slave (
        input  i_A, i_B, i_Select, i_Valid, i_Ready,
        output o_Ready, o_Out, o_Cout, o_Overflow, o_Zero, o_Negative, o_Valid
    );

    modport master (
        output i_A, i_B, i_Select, i_Valid, i_Ready,
        input  o_Ready, o_Out, o_Cout, o_Overflow, o_Zero, o_Negative, o_Valid
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: carry chain cut into STAGES slices, one register per slice.
// Optional signed saturation in the last stage when ADDSUB_SAT_EN is defined.
module addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic          i_Clk,
    input logic          i_Rst_n,
    addsub_pipe_if.slave bus
);
    localparam int S = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("addsub_pipe: illegal WIDTH/STAGES combination");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // The whole pipe advances together when the output slot is empty or being drained;
    // otherwise every stage, bubbles included, holds.
    logic adv;
    logic out_vld;
    assign adv         = !out_vld || bus.i_Ready;
    assign bus.o_Ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [S:0]       slice;
        logic [WIDTH-1:0] s_nx;

        if (k == 0) begin : g_first
            // B is pre-inverted for subtraction; the op then rides along as the carry chain.
            assign a_in = bus.i_A;
            assign b_in = bus.i_B ^ {WIDTH{bus.i_Select}};
            assign c_in = bus.i_Select;
            assign s_in = '0;
            assign v_in = bus.i_Valid;
        end else begin : g_next
            assign a_in = g_stg[k-1].g_reg.a_q;
            assign b_in = g_stg[k-1].g_reg.b_q;
            assign c_in = g_stg[k-1].g_reg.c_q;
            assign s_in = g_stg[k-1].g_reg.s_q;
            assign v_in = g_stg[k-1].g_reg.v_q;
        end

        assign slice = {1'b0, a_in[k*S +: S]} + {1'b0, b_in[k*S +: S]} + {{S{1'b0}}, c_in};

        always_comb begin
            s_nx            = s_in;
            s_nx[k*S +: S]  = slice[S-1:0];
        end

        if (k < L) begin : g_reg
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_in;
                    b_q <= b_in;
                    s_q <= s_nx;
                    c_q <= slice[S];
                    v_q <= v_in;
                end
            end
        end
    end

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             a_msb;
    logic             b_msb;
    logic             cout;
    logic             ovf;

    assign raw   = g_stg[L].s_nx;
    assign cout  = g_stg[L].slice[S];
    assign a_msb = g_stg[L].a_in[WIDTH-1];
    assign b_msb = g_stg[L].b_in[WIDTH-1];
    // Same as carry-in(MSB) ^ carry-out(MSB): like-signed operands giving an unlike-signed sum.
    assign ovf   = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

`ifdef ADDSUB_SAT_EN
    always_comb begin
        res = raw;
        if (ovf) begin
            res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res = raw;
`endif

    // Lower operand bits are already consumed by earlier slices when they reach the last stage.
    logic unused_tail;
    assign unused_tail = ^{g_stg[L].a_in, g_stg[L].b_in};

    logic [WIDTH-1:0] out_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            out_vld <= 1'b0;
        end else if (adv) begin
            out_q   <= res;
            cout_q  <= cout;
            ovf_q   <= ovf;
            zero_q  <= (res == '0);
            neg_q   <= res[WIDTH-1];
            out_vld <= g_stg[L].v_in;
        end
    end

    assign bus.o_Out      = out_q;
    assign bus.o_Cout     = cout_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_Zero     = zero_q;
    assign bus.o_Negative = neg_q;
    assign bus.o_Valid    = out_vld;
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: STAGES = 4, 1 and 32 instances share one stimulus stream.
module tb_addsub_pipe;
    localparam int W = 32;
`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sel;
        logic [W-1:0] out;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];
    int exp_lat[3];

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(W)) bus4();
    addsub_pipe_if #(.WIDTH(W)) bus1();
    addsub_pipe_if #(.WIDTH(W)) bus32();

    assign bus1.i_A       = bus4.i_A;
    assign bus1.i_B       = bus4.i_B;
    assign bus1.i_Select  = bus4.i_Select;
    assign bus1.i_Valid   = bus4.i_Valid;
    assign bus1.i_Ready   = 1'b1;
    assign bus32.i_A      = bus4.i_A;
    assign bus32.i_B      = bus4.i_B;
    assign bus32.i_Select = bus4.i_Select;
    assign bus32.i_Valid  = bus4.i_Valid;
    assign bus32.i_Ready  = 1'b1;

    addsub_pipe #(.WIDTH(W), .STAGES(4))  dut4  (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus4.slave));
    addsub_pipe #(.WIDTH(W), .STAGES(1))  dut1  (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus1.slave));
    addsub_pipe #(.WIDTH(W), .STAGES(32)) dut32 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus32.slave));

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pack_exp(input vec_t v);
        return {v.out, v.cout, v.ovf, v.zero, v.neg};
    endfunction

    function automatic logic [35:0] get_res(input int d);
        case (d)
            0:       return {bus4.o_Out, bus4.o_Cout, bus4.o_Overflow, bus4.o_Zero, bus4.o_Negative};
            1:       return {bus1.o_Out, bus1.o_Cout, bus1.o_Overflow, bus1.o_Zero, bus1.o_Negative};
            default: return {bus32.o_Out, bus32.o_Cout, bus32.o_Overflow, bus32.o_Zero, bus32.o_Negative};
        endcase
    endfunction

    function automatic logic get_vld(input int d);
        case (d)
            0:       return bus4.o_Valid;
            1:       return bus1.o_Valid;
            default: return bus32.o_Valid;
        endcase
    endfunction

    function automatic logic [36:0] snap4();
        return {get_res(0), bus4.o_Valid};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel, input logic vld);
        bus4.i_A      = a;
        bus4.i_B      = b;
        bus4.i_Select = sel;
        bus4.i_Valid  = vld;
    endtask

    task automatic run_vector(input int i);
        bit   seen[3];
        int   lat;
        logic all_seen;
        seen = '{1'b0, 1'b0, 1'b0};
        @(negedge clk);
        drive(vecs[i].a, vecs[i].b, vecs[i].sel, 1'b1);
        bus4.i_Ready = 1'b1;
        #1 check($sformatf("vec%0d_ready_in", i), bus4.o_Ready, 1);
        @(posedge clk);
        lat = 1;
        all_seen = 1'b0;
        while (!all_seen && lat <= 40) begin
            @(negedge clk);
            bus4.i_Valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && get_vld(d)) begin
                    seen[d] = 1'b1;
                    check($sformatf("vec%0d_res_dut%0d", i, d), get_res(d), pack_exp(vecs[i]));
                    check($sformatf("vec%0d_lat_dut%0d", i, d), lat, exp_lat[d]);
                end
            end
            all_seen = seen[0] && seen[1] && seen[2];
            if (!all_seen) begin
                @(posedge clk);
                lat++;
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (!seen[d]) begin
                check($sformatf("vec%0d_timeout_dut%0d", i, d), 0, 1);
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [36:0] hold;
        logic        stale;
        int          sent;
        int          got;
        logic        stall;

        exp_lat = '{4, 1, 32};
        vecs[0]  = '{a:32'd5, b:32'd3, sel:1'b0, out:32'd8, cout:1'b0, ovf:1'b0, zero:1'b0, neg:1'b0};
        vecs[1]  = '{a:32'd3, b:32'd5, sel:1'b1, out:32'hFFFF_FFFE, cout:1'b0, ovf:1'b0, zero:1'b0, neg:1'b1};
        vecs[2]  = '{a:32'd5, b:32'd5, sel:1'b1, out:32'd0, cout:1'b1, ovf:1'b0, zero:1'b1, neg:1'b0};
        vecs[3]  = '{a:32'h7FFF_FFFF, b:32'd1, sel:1'b0,
                     out:(SAT ? 32'h7FFF_FFFF : 32'h8000_0000), cout:1'b0, ovf:1'b1, zero:1'b0, neg:!SAT};
        vecs[4]  = '{a:32'h8000_0000, b:32'd1, sel:1'b1,
                     out:(SAT ? 32'h8000_0000 : 32'h7FFF_FFFF), cout:1'b1, ovf:1'b1, zero:1'b0, neg:SAT};
        vecs[5]  = '{a:32'hFFFF_FFFF, b:32'd1, sel:1'b0, out:32'd0, cout:1'b1, ovf:1'b0, zero:1'b1, neg:1'b0};
        vecs[6]  = '{a:32'h8000_0000, b:32'h8000_0000, sel:1'b0,
                     out:(SAT ? 32'h8000_0000 : 32'd0), cout:1'b1, ovf:1'b1, zero:!SAT, neg:SAT};
        vecs[7]  = '{a:32'h0000_FFFF, b:32'd1, sel:1'b0, out:32'h0001_0000, cout:1'b0, ovf:1'b0, zero:1'b0, neg:1'b0};
        vecs[8]  = '{a:32'd0, b:32'd1, sel:1'b1, out:32'hFFFF_FFFF, cout:1'b0, ovf:1'b0, zero:1'b0, neg:1'b1};
        vecs[9]  = '{a:32'h1234_5678, b:32'h0FED_CBA9, sel:1'b0, out:32'h2222_2221, cout:1'b0, ovf:1'b0, zero:1'b0, neg:1'b0};
        vecs[10] = '{a:32'h7FFF_FFFF, b:32'hFFFF_FFFF, sel:1'b1,
                     out:(SAT ? 32'h7FFF_FFFF : 32'h8000_0000), cout:1'b0, ovf:1'b1, zero:1'b0, neg:!SAT};

        drive('0, '0, 1'b0, 1'b0);
        bus4.i_Ready = 1'b0;

        // reset state
        #3;
        check("rst_res_dut4", get_res(0), 0);
        check("rst_valid_dut4", bus4.o_Valid, 0);
        check("rst_ready_dut4", bus4.o_Ready, 1);
        check("rst_valid_dut1", bus1.o_Valid, 0);
        check("rst_valid_dut32", bus32.o_Valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven single operations on all three pipelines
        for (int i = 0; i < NV; i++) begin
            run_vector(i);
        end

        // reset while three operations are in flight and one is held at the output
        @(negedge clk);
        bus4.i_Ready = 1'b0;
        drive(32'h11, 32'h22, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h44, 32'h11, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h100, 32'h1, 1'b0, 1'b1);
        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_held_valid", bus4.o_Valid, 1);
        check("mid_held_out", bus4.o_Out, 32'h33);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus4.o_Valid, 0);
        check("mid_rst_res", get_res(0), 0);
        check("mid_rst_ready", bus4.o_Ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus4.i_Ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus4.o_Valid || bus1.o_Valid || bus32.o_Valid) stale = 1'b1;
        end
        check("no_stale_after_rst", stale, 0);

        // 10-op stream with a 3-cycle downstream stall
        sent = 0;
        got  = 0;
        hold = '0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            stall = (cyc >= 5 && cyc <= 7);
            bus4.i_Ready = !stall;
            if (sent < 10) drive(W'(sent), W'(sent), 1'b0, 1'b1);
            else           drive('0, '0, 1'b0, 1'b0);
            #1;
            check($sformatf("stream_ready_c%0d", cyc), bus4.o_Ready, !bus4.o_Valid || bus4.i_Ready);
            if (stall) check($sformatf("stall_ready_c%0d", cyc), bus4.o_Ready, 0);
            if (cyc == 5) hold = snap4();
            if (cyc >= 6 && cyc <= 8) check($sformatf("stall_hold_c%0d", cyc), snap4(), hold);
            if (bus4.o_Valid && bus4.i_Ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_result", bus4.o_Out, 32'hDEAD_BEEF);
                end else begin
                    check($sformatf("stream_res%0d", got), bus4.o_Out, exp_q.pop_front());
                end
                got++;
            end
            if (bus4.i_Valid && bus4.o_Ready) begin
                exp_q.push_back(W'(2 * sent));
                sent++;
            end
        end
        check("stream_count", got, 10);
        check("stream_q_empty", exp_q.size(), 0);

        @(negedge clk);
        drive('0, '0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
